// File: rtl/cla_sub_serial_pkg.sv
// cla_sub_pkg: shared types and sizing helpers for the serial borrow-lookahead subtractor
package cla_sub_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NIBBLE_W = 4;
   function automatic int nib_count(input int width);
      return width / NIBBLE_W;
   endfunction
   function automatic int cnt_w(input int width);
      return (nib_count(width) > 1) ? $clog2(nib_count(width)) : 1;
   endfunction
endpackage

// File: rtl/cla_sub_serial_if.sv
// cla_sub_serial_if: operand request / result handshake bundle
interface cla_sub_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             ovf;
   logic             zero;
   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, diff, b_out, ovf, zero
   );
   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, diff, b_out, ovf, zero
   );
endinterface

// File: rtl/cla_sub_serial_cla4_sub.sv
// cla4_sub: combinational 4-bit borrow-lookahead slice, a - b - bin via a + ~b + ~bin
module cla4_sub
   import cla_sub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                bin,
   output logic [NIBBLE_W-1:0] d,
   output logic                bout
);
   logic [NIBBLE_W-1:0] w_bn;
   logic [NIBBLE_W-1:0] w_g;
   logic [NIBBLE_W-1:0] w_p;
   logic [NIBBLE_W:0]   w_c;
   assign w_bn = ~b;
   assign w_g  = a & w_bn;
   assign w_p  = a ^ w_bn;
   assign w_c[0] = ~bin;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   // a carry out of the inverted-subtrahend sum means no borrow was needed
   assign d    = w_p ^ w_c[NIBBLE_W-1:0];
   assign bout = ~w_c[NIBBLE_W];
endmodule

// File: rtl/cla_sub_serial.sv
// cla_sub_serial: multi-cycle subtractor reusing one 4-bit lookahead slice, one nibble per cycle
module cla_sub_serial
   import cla_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic             clk,
   input logic             rst_n,
   cla_sub_serial_if.slave bus
);
   localparam int NIB = nib_count(WIDTH);
   localparam int KW  = cnt_w(WIDTH);
   localparam logic [KW-1:0] LAST = KW'(NIB - 1);

   generate
      if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
         $error("cla_sub_serial: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   state_t              r_state;
   state_t              w_next;
   logic [KW-1:0]       r_k;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_diff;
   logic                r_bor;
   logic                w_accept;
   logic                w_bo;
   logic [NIBBLE_W-1:0] w_d;
   logic [KW+1:0]       w_lo;

   assign w_lo = {r_k, 2'b00};

   cla4_sub u_slice (
      .a    (r_a[w_lo +: NIBBLE_W]),
      .b    (r_b[w_lo +: NIBBLE_W]),
      .bin  (r_bor),
      .d    (w_d),
      .bout (w_bo)
   );

   // next state and handshake flags, decoded from state only (rst_n just masks in_ready)
   always_comb begin
      w_next        = r_state;
      w_accept      = (r_state == IDLE) && bus.in_valid;
      bus.in_ready  = rst_n && (r_state == IDLE);
      bus.out_valid = (r_state == DONE);
      if (w_accept)
         w_next = RUN;
      else if (r_state == RUN && r_k == LAST)
         w_next = DONE;
      else if (r_state == DONE && bus.out_ready)
         w_next = IDLE;
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // operand capture and nibble-serial datapath; borrow chains through r_bor between cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_k    <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_diff <= '0;
         r_bor  <= 1'b0;
      end else if (w_accept) begin
         r_k    <= '0;
         r_a    <= bus.a;
         r_b    <= bus.b;
         r_diff <= '0;
         r_bor  <= bus.b_in;
      end else if (r_state == RUN) begin
         r_diff[w_lo +: NIBBLE_W] <= w_d;
         r_bor                    <= w_bo;
         r_k                      <= r_k + KW'(1);
      end
   end

   assign bus.diff  = r_diff;
   assign bus.b_out = r_bor;
   assign bus.ovf   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_diff[WIDTH-1] ^ r_a[WIDTH-1]);
   assign bus.zero  = (r_state == DONE) && ~|r_diff;
endmodule
